// File: rtl/lsu_wb_pkg.sv
// Shared types and constants for the load/store writeback unit: FSM states,
// RV funct3 access encodings, and the default datapath and register-index widths.
package lsu_wb_pkg;

  localparam int XLEN_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Unshifted byte-lane mask for an access size.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load alignment and extension: shifts the response word down to the accessed
// byte offset, then sign- or zero-extends according to funct3.
module lsu_ext
  import lsu_wb_pkg::*;
#(
  parameter int XLEN = XLEN_W
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      LB:      data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LH:      data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LBU:     data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LHU:     data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// Load/store unit with writeback: IDLE -> REQ -> WAIT -> WB for memory ops,
// IDLE -> WB otherwise. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_wb
  import lsu_wb_pkg::*;
#(
  parameter int XLEN = XLEN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [REG_W-1:0] rd_i,
  input  logic             wen_i,
  input  logic             is_load_i,
  input  logic             is_store_i,
  input  logic [2:0]       funct3_i,
  input  logic [XLEN-1:0]  alu_res_i,
  input  logic [XLEN-1:0]  st_data_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic             mem_wen_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  output logic [3:0]       mem_wstrb_o,
  input  logic             mem_rsp_valid_i,
  input  logic [XLEN-1:0]  mem_rdata_i,
  input  logic             mem_rsp_err_i,
  output logic             wb_wen_o,
  output logic [REG_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]  wb_data_o,
  output logic             retire_o,
  output logic             err_o
);

  state_t           state;
  logic [REG_W-1:0] rd_q;
  logic             wen_q, load_q, store_q, err_q;
  logic [2:0]       f3_q;
  logic [XLEN-1:0]  alu_q, st_q, rdata_q, ext_data;
  logic             misalign;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (is_load_i | is_store_i) &
                    (((funct3_i[1:0] == 2'b01) & alu_res_i[0]) |
                     ((funct3_i[1:0] == 2'b10) & (|alu_res_i[1:0])));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      rd_q    <= '0;
      wen_q   <= 1'b0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      alu_q   <= '0;
      st_q    <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid_i) begin
          rd_q    <= rd_i;
          wen_q   <= wen_i;
          load_q  <= is_load_i;
          store_q <= is_store_i;
          f3_q    <= funct3_i;
          alu_q   <= alu_res_i;
          st_q    <= st_data_i;
          err_q   <= misalign;
          // A trapped access skips the bus entirely.
          if (!(is_load_i | is_store_i) || misalign) state <= WB;
          else                                       state <= REQ;
        end
        REQ: if (mem_req_ready_i) state <= WAIT;
        WAIT: if (mem_rsp_valid_i) begin
          rdata_q <= mem_rdata_i;
          err_q   <= mem_rsp_err_i;
          state   <= WB;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  lsu_ext #(.XLEN(XLEN)) u_ext (
    .funct3 (f3_q),
    .offset (alu_q[1:0]),
    .rdata  (rdata_q),
    .data   (ext_data)
  );

  assign in_ready_o      = (state == IDLE);
  assign mem_req_valid_o = (state == REQ);
  assign mem_addr_o      = {alu_q[XLEN-1:2], 2'b00};
  assign mem_wen_o       = store_q;
  assign mem_wstrb_o     = store_q ? (size_mask(f3_q) << alu_q[1:0]) : 4'b0000;
  assign mem_wdata_o     = st_q << {alu_q[1:0], 3'b000};

  assign retire_o  = (state == WB);
  assign err_o     = retire_o & err_q;
  assign wb_wen_o  = retire_o & wen_q & ~store_q & ~err_q & (rd_q != '0);
  assign wb_rd_o   = rd_q;
  assign wb_data_o = load_q ? ext_data : alu_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Scoreboard bench for lsu_wb: stimulus pushes expected writeback records,
// a monitor pops and compares them whenever retire_o is seen.
module tb_lsu_wb;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        in_valid_i, in_ready_o;
  logic [4:0]  rd_i;
  logic        wen_i, is_load_i, is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_res_i, st_data_i;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_wen_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_rsp_valid_i, mem_rsp_err_i;
  logic [31:0] mem_rdata_i;
  logic        wb_wen_o, retire_o, err_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;

  always #5 clk = ~clk;

  lsu_wb #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rd_i(rd_i), .wen_i(wen_i), .is_load_i(is_load_i), .is_store_i(is_store_i),
    .funct3_i(funct3_i), .alu_res_i(alu_res_i), .st_data_i(st_data_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rdata_i(mem_rdata_i), .mem_rsp_err_i(mem_rsp_err_i),
    .wb_wen_o(wb_wen_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .retire_o(retire_o), .err_o(err_o)
  );

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } wb_t;

  wb_t q[$];
  wb_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      if (retire_o) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_retire: got retire_o=1, expected no retire");
        end else begin
          mon_e = q.pop_front();
          chk("wb_wen", 32'(wb_wen_o), 32'(mon_e.wen));
          chk("wb_rd", 32'(wb_rd_o), 32'(mon_e.rd));
          chk("wb_data", wb_data_o, mon_e.data);
          chk("err", 32'(err_o), 32'(mon_e.err));
        end
      end else begin
        chk("quiet_outside_wb", 32'({wb_wen_o, err_o}), 32'd0);
      end
    end
  end

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d pending, expected 0", nm, q.size());
      q.delete();
    end
  endtask

  task automatic do_op(input string nm, input logic [4:0] rd, input logic wen,
                       input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] sd, input int rdy_dly,
                       input logic [31:0] rdata, input logic rerr,
                       input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic [3:0] e_strb, input logic e_wen,
                       input logic [31:0] e_data, input logic e_err);
    wb_t e;
    e.wen = e_wen; e.rd = rd; e.data = e_data; e.err = e_err;
    q.push_back(e);
    @(negedge clk);
    chk({nm, "_in_ready"}, 32'(in_ready_o), 32'd1);
    rd_i = rd; wen_i = wen; is_load_i = ld; is_store_i = st; funct3_i = f3;
    alu_res_i = alu; st_data_i = sd; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0;
    alu_res_i = 32'hFFFF_FFFF; st_data_i = 32'hFFFF_FFFF;
    if (ld || st) begin
      for (int i = 0; i <= rdy_dly; i++) begin
        chk({nm, "_req_valid"}, 32'(mem_req_valid_o), 32'd1);
        chk({nm, "_addr"}, mem_addr_o, e_addr);
        chk({nm, "_wdata"}, mem_wdata_o, e_wdata);
        chk({nm, "_wstrb"}, 32'(mem_wstrb_o), 32'(e_strb));
        chk({nm, "_mem_wen"}, 32'(mem_wen_o), 32'(st));
        if (i == rdy_dly) mem_req_ready_i = 1'b1;
        @(negedge clk);
      end
      mem_req_ready_i = 1'b0;
      mem_rsp_valid_i = 1'b1; mem_rdata_i = rdata; mem_rsp_err_i = rerr;
      @(negedge clk);
      mem_rsp_valid_i = 1'b0; mem_rsp_err_i = 1'b0;
    end else begin
      chk({nm, "_no_req"}, 32'(mem_req_valid_o), 32'd0);
    end
    drain(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; in_valid_i = 1'b0; rd_i = '0; wen_i = 1'b0; is_load_i = 1'b0;
    is_store_i = 1'b0; funct3_i = '0; alu_res_i = '0; st_data_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rdata_i = '0; mem_rsp_err_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst_retire", 32'({retire_o, wb_wen_o, err_o}), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    rst_i = 1'b1;

    //     name   rd  wen ld st f3    alu           sd            dly rdata         err  addr          wdata         strb     ewen edata         eerr
    do_op("add",  5,  1, 0, 0, 3'b000, 32'h0000_1234, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        4'b0000, 1, 32'h0000_1234, 0);
    do_op("lb",   7,  1, 1, 0, 3'b000, 32'h0000_1003, 32'h0,        0, 32'h80FF_FFFF, 0, 32'h0000_1000, 32'h0,       4'b0000, 1, 32'hFFFF_FF80, 0);
    do_op("lbu",  7,  1, 1, 0, 3'b100, 32'h0000_1003, 32'h0,        0, 32'h80FF_FFFF, 0, 32'h0000_1000, 32'h0,       4'b0000, 1, 32'h0000_0080, 0);
    do_op("sh",   2,  1, 0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 3, 32'h0,        0, 32'h0000_2000, 32'hBEEF_0000, 4'b1100, 0, 32'h0000_2002, 0);
    do_op("lw_x0",0,  1, 1, 0, 3'b010, 32'h0000_3000, 32'h0,        0, 32'hDEAD_BEEF, 0, 32'h0000_3000, 32'h0,       4'b0000, 0, 32'hDEAD_BEEF, 0);
    do_op("lw_err",3, 1, 1, 0, 3'b010, 32'h0000_3004, 32'h0,        1, 32'h1122_3344, 1, 32'h0000_3004, 32'h0,       4'b0000, 0, 32'h1122_3344, 1);
    do_op("lh",   9,  1, 1, 0, 3'b001, 32'h0000_4002, 32'h0,        0, 32'h8001_1234, 0, 32'h0000_4000, 32'h0,       4'b0000, 1, 32'hFFFF_8001, 0);
    do_op("lhu",  10, 1, 1, 0, 3'b101, 32'h0000_4000, 32'h0,        0, 32'h0000_F00D, 0, 32'h0000_4000, 32'h0,       4'b0000, 1, 32'h0000_F00D, 0);
    do_op("sb",   1,  0, 0, 1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 0, 32'h0,        0, 32'h0000_5000, 32'h0000_A500, 4'b0010, 0, 32'h0000_5001, 0);
    do_op("sw",   1,  0, 0, 1, 3'b010, 32'h0000_6000, 32'hCAFE_BABE, 2, 32'h0,        0, 32'h0000_6000, 32'hCAFE_BABE, 4'b1111, 0, 32'h0000_6000, 0);
    do_op("nowen",4,  0, 0, 0, 3'b000, 32'h0000_0042, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        4'b0000, 0, 32'h0000_0042, 0);
    do_op("lw31", 31, 1, 1, 0, 3'b010, 32'h0000_7000, 32'h0,        0, 32'h1234_5678, 0, 32'h0000_7000, 32'h0,       4'b0000, 1, 32'h1234_5678, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    do_op("lh_mis",6, 1, 1, 0, 3'b001, 32'h0000_4003, 32'h0,        0, 32'hAB00_0000, 0, 32'h0000_4000, 32'h0,       4'b0000, 1, 32'h0000_00AB, 0);
    do_op("sw_mis",1, 0, 0, 1, 3'b010, 32'h0000_6001, 32'h1122_3344, 0, 32'h0,        0, 32'h0000_6000, 32'h2233_4400, 4'b1110, 0, 32'h0000_6001, 0);
`endif

    // Reset while waiting for a response; the late response must be ignored.
    @(negedge clk);
    rd_i = 5'd8; wen_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010;
    alu_res_i = 32'h0000_8000; in_valid_i = 1'b1;
    @(negedge clk);
    in_valid_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    chk("wait_in_ready", 32'(in_ready_o), 32'd0);
    #2 rst_i = 1'b0;
    #1;
    chk("async_in_ready", 32'(in_ready_o), 32'd1);
    chk("async_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("async_outs", 32'({retire_o, wb_wen_o, err_o}), 32'd0);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    mem_rsp_valid_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    chk("late_rsp_retire", 32'({retire_o, wb_wen_o}), 32'd0);
    chk("late_rsp_in_ready", 32'(in_ready_o), 32'd1);
    @(negedge clk);
    chk("late_rsp_retire2", 32'({retire_o, wb_wen_o}), 32'd0);

    do_op("post", 12, 1, 0, 0, 3'b000, 32'h0000_0777, 32'h0, 0, 32'h0, 0, 32'h0, 32'h0, 4'b0000, 1, 32'h0000_0777, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
